// File: rtl/isa_pkg.sv
// -----------------------------------------------------------------------------
// isa_pkg
// Shared definitions for the team's 32-bit ISA: mnemonic enum, 6-bit primary
// opcodes, field bit positions and the NOP word. Used by the encoder/loader
// and by the standalone field packer.
// -----------------------------------------------------------------------------
package isa_pkg;

    // Mnemonic codes carried on in_op; values 11..15 are undefined.
    typedef enum logic [3:0] {
        OP_LW   = 4'd0,
        OP_SW   = 4'd1,
        OP_ADD  = 4'd2,
        OP_JR   = 4'd3,
        OP_JAL  = 4'd4,
        OP_NOR  = 4'd5,
        OP_NORI = 4'd6,
        OP_NOT  = 4'd7,
        OP_BLEU = 4'd8,
        OP_ROLV = 4'd9,
        OP_RORV = 4'd10
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PAD  = 1'b1
    } state_e;

    // Primary opcodes, placed in ins[31:26].
    localparam logic [5:0] OPC_LW   = 6'b100011;
    localparam logic [5:0] OPC_SW   = 6'b101011;
    localparam logic [5:0] OPC_ADD  = 6'b100000;
    localparam logic [5:0] OPC_JR   = 6'b001000;
    localparam logic [5:0] OPC_JAL  = 6'b000011;
    localparam logic [5:0] OPC_NOR  = 6'b100110;
    localparam logic [5:0] OPC_NORI = 6'b001110;
    localparam logic [5:0] OPC_NOT  = 6'b000100;
    localparam logic [5:0] OPC_BLEU = 6'b010000;
    localparam logic [5:0] OPC_ROLV = 6'b000000;
    localparam logic [5:0] OPC_RORV = 6'b000010;

    // Field LSB positions and widths.
    localparam int OPC_LSB = 26;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;
    localparam int OPC_W   = 6;
    localparam int REG_W   = 5;
    localparam int IMM_W   = 16;
    localparam int TGT_W   = 26;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/ins_encoder_loader_if.sv
// -----------------------------------------------------------------------------
// ins_encoder_loader_if
// Request handshake (decoded instruction in) plus instruction-memory write port.
//   master : request producer / memory observer (program loader, test harness)
//   slave  : the encoder/loader
// Signals:
//   in_valid/in_ready         request handshake
//   in_op, in_rs/rt/rd,
//   in_imm, in_target         decoded instruction fields
//   imem_we/addr/wdata        sequential instruction-memory write port
// -----------------------------------------------------------------------------
interface ins_encoder_loader_if #(
    parameter int AW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [4:0]    in_rs;
    logic [4:0]    in_rt;
    logic [4:0]    in_rd;
    logic [15:0]   in_imm;
    logic [25:0]   in_target;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/ins_field_pack.sv
// -----------------------------------------------------------------------------
// ins_field_pack
// Purely combinational mnemonic/fields -> 32-bit instruction word packer.
// Ports:
//   op              mnemonic (op_e encoding, 4 bits)
//   rs, rt, rd      register fields
//   imm             16-bit immediate
//   target          26-bit jump target
//   word            packed instruction (NOP_WORD when illegal)
//   illegal         op is not a defined mnemonic
//   is_ctrl         op is a control transfer (BLEU/JR/JAL)
// -----------------------------------------------------------------------------
module ins_field_pack
    import isa_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal,
    output logic        is_ctrl
);
    logic [31:0] rs_f, rt_f, rd_f, imm_f, tgt_f;
    logic [5:0]  opc;

    assign rs_f  = 32'(rs) << RS_LSB;
    assign rt_f  = 32'(rt) << RT_LSB;
    assign rd_f  = 32'(rd) << RD_LSB;
    assign imm_f = 32'(imm);
    assign tgt_f = 32'(target);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a variable unassigned, which would infer a latch.
        word    = NOP_WORD;
        opc     = 6'b0;
        illegal = 1'b0;
        is_ctrl = 1'b0;
        case (op)
            OP_ADD:  begin opc = OPC_ADD;  word = rs_f | rt_f | rd_f;  end
            OP_NOR:  begin opc = OPC_NOR;  word = rs_f | rt_f | rd_f;  end
            OP_ROLV: begin opc = OPC_ROLV; word = rs_f | rt_f | rd_f;  end
            OP_RORV: begin opc = OPC_RORV; word = rs_f | rt_f | rd_f;  end
            OP_LW:   begin opc = OPC_LW;   word = rs_f | rt_f | imm_f; end
            OP_SW:   begin opc = OPC_SW;   word = rs_f | rt_f | imm_f; end
            OP_NORI: begin opc = OPC_NORI; word = rs_f | rt_f | imm_f; end
            OP_BLEU: begin opc = OPC_BLEU; word = rs_f | rt_f | imm_f; is_ctrl = 1'b1; end
            OP_NOT:  begin opc = OPC_NOT;  word = rs_f | rt_f;         end
            OP_JR:   begin opc = OPC_JR;   word = rs_f;                is_ctrl = 1'b1; end
            OP_JAL:  begin opc = OPC_JAL;  word = tgt_f;               is_ctrl = 1'b1; end
            default: illegal = 1'b1;
        endcase
        if (!illegal) begin
            word = word | (32'(opc) << OPC_LSB);
        end
    end
endmodule

// File: rtl/ins_encoder_loader.sv
// -----------------------------------------------------------------------------
// ins_encoder_loader
// Accepts decoded instruction requests, packs each into a 32-bit word and writes
// it to the next instruction-memory address (base + count). Control transfers
// are optionally followed by a NOP delay-slot word.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, base_addr    restart a program at base_addr, clear count and flags
//   bus (slave)         request handshake + imem write port
//   count               words written since start
//   full                count == DEPTH
//   illegal             sticky: an undefined mnemonic was consumed
//   overflow            sticky: a delay-slot NOP was dropped for lack of space
// -----------------------------------------------------------------------------
module ins_encoder_loader
    import isa_pkg::*;
#(
    parameter int AW             = 8,
    parameter int DEPTH          = 256,
    parameter bit PAD_DELAY_SLOT = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [AW-1:0]        base_addr,
    ins_encoder_loader_if.slave  bus,
    output logic [AW:0]          count,
    output logic                 full,
    output logic                 illegal,
    output logic                 overflow
);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_e        state, state_nxt;
    logic [AW-1:0] base_q;
    logic [AW-1:0] wr_addr;
    logic [31:0]   packed_word;
    logic          op_illegal, op_ctrl;
    logic          accept, pad_fire, last_slot, want_pad;

    ins_field_pack u_pack (
        .op      (bus.in_op),
        .rs      (bus.in_rs),
        .rt      (bus.in_rt),
        .rd      (bus.in_rd),
        .imm     (bus.in_imm),
        .target  (bus.in_target),
        .word    (packed_word),
        .illegal (op_illegal),
        .is_ctrl (op_ctrl)
    );

    assign full      = (count == DEPTH_W);
    // The word being written now occupies the final slot: no room for a pad.
    assign last_slot = ((count + (AW+1)'(1)) == DEPTH_W);
    assign want_pad  = PAD_DELAY_SLOT && op_ctrl;
    // Wraps modulo 2^AW by truncation.
    assign wr_addr   = base_q + count[AW-1:0];
    assign accept    = bus.in_valid && bus.in_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; start abandons a pending pad.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept && want_pad && !last_slot) state_nxt = ST_PAD;
                ST_PAD:  state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output logic; start and reset both block acceptance in their cycle.
    always_comb begin
        bus.in_ready = 1'b0;
        pad_fire     = 1'b0;
        case (state)
            ST_IDLE: bus.in_ready = !full && !start && !reset;
            ST_PAD:  pad_fire     = !start;
            default: ;
        endcase
    end

    // Write port, counter and sticky flags.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            base_q         <= '0;
            count          <= '0;
            illegal        <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            bus.imem_we <= 1'b0;
            if (start) begin
                base_q   <= base_addr;
                count    <= '0;
                illegal  <= 1'b0;
                overflow <= 1'b0;
            end else if (accept) begin
                if (op_illegal) begin
                    illegal <= 1'b1;
                end else begin
                    bus.imem_we    <= 1'b1;
                    bus.imem_addr  <= wr_addr;
                    bus.imem_wdata <= packed_word;
                    count          <= count + (AW+1)'(1);
                    if (want_pad && last_slot) overflow <= 1'b1;
                end
            end else if (pad_fire) begin
                bus.imem_we    <= 1'b1;
                bus.imem_addr  <= wr_addr;
                bus.imem_wdata <= NOP_WORD;
                count          <= count + (AW+1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_ins_encoder_loader.sv
// -----------------------------------------------------------------------------
// tb_ins_encoder_loader
// Directed bench: dut_a (DEPTH=256) runs a table of every mnemonic plus the
// illegal/wrap/start/reset sequences; dut_b (DEPTH=4) covers the dropped pad.
// -----------------------------------------------------------------------------
module tb_ins_encoder_loader;
    import isa_pkg::*;

    localparam int AW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          start_a, start_b;
    logic [AW-1:0] base_a, base_b;
    logic [AW:0]   count_a, count_b;
    logic          full_a, full_b, illegal_a, illegal_b, overflow_a, overflow_b;

    ins_encoder_loader_if #(.AW(AW)) bus_a ();
    ins_encoder_loader_if #(.AW(AW)) bus_b ();

    ins_encoder_loader #(.AW(AW), .DEPTH(256), .PAD_DELAY_SLOT(1'b1)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .base_addr(base_a), .bus(bus_a),
        .count(count_a), .full(full_a), .illegal(illegal_a), .overflow(overflow_a)
    );

    ins_encoder_loader #(.AW(AW), .DEPTH(4), .PAD_DELAY_SLOT(1'b1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .base_addr(base_b), .bus(bus_b),
        .count(count_b), .full(full_b), .illegal(illegal_b), .overflow(overflow_b)
    );

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [25:0] target;
        logic [31:0] word;
        bit          pad;
    } vec_t;

    vec_t vecs[11];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input string name, input logic [3:0] op, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                                input logic [25:0] target, input logic [31:0] word, input bit pad);
        vec_t v;
        v.name = name; v.op = op; v.rs = rs; v.rt = rt; v.rd = rd;
        v.imm = imm; v.target = target; v.word = word; v.pad = pad;
        return v;
    endfunction

    task automatic drive_a(input vec_t v);
        bus_a.in_op = v.op; bus_a.in_rs = v.rs; bus_a.in_rt = v.rt; bus_a.in_rd = v.rd;
        bus_a.in_imm = v.imm; bus_a.in_target = v.target;
    endtask

    task automatic drive_b(input vec_t v);
        bus_b.in_op = v.op; bus_b.in_rs = v.rs; bus_b.in_rt = v.rt; bus_b.in_rd = v.rd;
        bus_b.in_imm = v.imm; bus_b.in_target = v.target;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          add_v, jal_v, bleu_v, bad_v;
        int            exp_cnt;
        logic [AW-1:0] exp_base;
        logic [AW-1:0] ea;

        vecs[0]  = mk("ADD",  OP_ADD,  5'd1,  5'd2, 5'd3, 16'h0000, 26'h0,  32'h80221800, 1'b0);
        vecs[1]  = mk("LW",   OP_LW,   5'd4,  5'd5, 5'd0, 16'hFFFC, 26'h0,  32'h8C85FFFC, 1'b0);
        vecs[2]  = mk("NOT",  OP_NOT,  5'd1,  5'd2, 5'd0, 16'h0000, 26'h0,  32'h10220000, 1'b0);
        vecs[3]  = mk("JAL",  OP_JAL,  5'd0,  5'd0, 5'd0, 16'h0000, 26'h40, 32'h0C000040, 1'b1);
        vecs[4]  = mk("SW",   OP_SW,   5'd3,  5'd7, 5'd0, 16'h1234, 26'h0,  32'hAC671234, 1'b0);
        vecs[5]  = mk("JR",   OP_JR,   5'd31, 5'd0, 5'd0, 16'h0000, 26'h0,  32'h23E00000, 1'b1);
        vecs[6]  = mk("NOR",  OP_NOR,  5'd2,  5'd3, 5'd4, 16'h0000, 26'h0,  32'h98432000, 1'b0);
        vecs[7]  = mk("NORI", OP_NORI, 5'd1,  5'd1, 5'd0, 16'h00FF, 26'h0,  32'h382100FF, 1'b0);
        vecs[8]  = mk("ROLV", OP_ROLV, 5'd5,  5'd6, 5'd7, 16'h0000, 26'h0,  32'h00A63800, 1'b0);
        vecs[9]  = mk("RORV", OP_RORV, 5'd5,  5'd6, 5'd7, 16'h0000, 26'h0,  32'h08A63800, 1'b0);
        vecs[10] = mk("BLEU", OP_BLEU, 5'd1,  5'd2, 5'd0, 16'h8000, 26'h0,  32'h40228000, 1'b1);

        add_v  = vecs[0];
        jal_v  = mk("JAL2", OP_JAL, 5'd0, 5'd0, 5'd0, 16'h0, 26'h123, 32'h0C000123, 1'b1);
        bleu_v = mk("BLEU8", OP_BLEU, 5'd0, 5'd0, 5'd0, 16'h0008, 26'h0, 32'h40000008, 1'b1);
        bad_v  = mk("BAD", 4'hF, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0, 1'b0);

        // ---------------- reset state ----------------
        reset = 1'b1;
        start_a = 1'b0; start_b = 1'b0; base_a = '0; base_b = '0;
        bus_a.in_valid = 1'b0; bus_b.in_valid = 1'b0;
        drive_a(add_v); drive_b(add_v);
        tick; tick;
        check("rst we",       32'(bus_a.imem_we),    32'h0);
        check("rst addr",     32'(bus_a.imem_addr),  32'h0);
        check("rst wdata",    bus_a.imem_wdata,      32'h0);
        check("rst count",    32'(count_a),          32'h0);
        check("rst full",     32'(full_a),           32'h0);
        check("rst illegal",  32'(illegal_a),        32'h0);
        check("rst overflow", 32'(overflow_a),       32'h0);
        check("rst ready",    32'(bus_a.in_ready),   32'h0);
        check("rst b count",  32'(count_b),          32'h0);
        reset = 1'b0;
        #1;
        check("post-rst ready", 32'(bus_a.in_ready), 32'h1);

        // ---------------- start has priority over a valid request ----------------
        base_a = 8'h10; start_a = 1'b1; bus_a.in_valid = 1'b1;
        #1;
        check("start ready", 32'(bus_a.in_ready), 32'h0);
        tick;
        start_a = 1'b0; bus_a.in_valid = 1'b0;
        check("start no we",  32'(bus_a.imem_we), 32'h0);
        check("start count",  32'(count_a),       32'h0);

        // ---------------- table of every mnemonic ----------------
        exp_base = 8'h10;
        exp_cnt  = 0;
        for (int i = 0; i < 11; i++) begin
            drive_a(vecs[i]);
            bus_a.in_valid = 1'b1;
            #1;
            check({vecs[i].name, " ready"}, 32'(bus_a.in_ready), 32'h1);
            tick;
            bus_a.in_valid = 1'b0;
            ea = exp_base + AW'(exp_cnt);
            exp_cnt++;
            check({vecs[i].name, " we"},    32'(bus_a.imem_we),   32'h1);
            check({vecs[i].name, " addr"},  32'(bus_a.imem_addr), 32'(ea));
            check({vecs[i].name, " wdata"}, bus_a.imem_wdata,     vecs[i].word);
            check({vecs[i].name, " count"}, 32'(count_a),         32'(exp_cnt));
            if (vecs[i].pad) begin
                check({vecs[i].name, " pad ready"}, 32'(bus_a.in_ready), 32'h0);
                tick;
                ea = exp_base + AW'(exp_cnt);
                exp_cnt++;
                check({vecs[i].name, " nop we"},    32'(bus_a.imem_we),   32'h1);
                check({vecs[i].name, " nop addr"},  32'(bus_a.imem_addr), 32'(ea));
                check({vecs[i].name, " nop wdata"}, bus_a.imem_wdata,     32'h0);
                check({vecs[i].name, " nop count"}, 32'(count_a),         32'(exp_cnt));
            end
            #1;
            check({vecs[i].name, " idle ready"}, 32'(bus_a.in_ready), 32'h1);
        end

        // ---------------- illegal mnemonic ----------------
        drive_a(bad_v);
        bus_a.in_valid = 1'b1;
        tick;
        bus_a.in_valid = 1'b0;
        check("illegal no we", 32'(bus_a.imem_we), 32'h0);
        check("illegal flag",  32'(illegal_a),     32'h1);
        check("illegal count", 32'(count_a),       32'(exp_cnt));
        drive_a(add_v);
        bus_a.in_valid = 1'b1;
        tick;
        bus_a.in_valid = 1'b0;
        ea = exp_base + AW'(exp_cnt);
        check("after illegal addr",  32'(bus_a.imem_addr), 32'(ea));
        check("after illegal wdata", bus_a.imem_wdata,     32'h80221800);
        check("illegal sticky",      32'(illegal_a),       32'h1);

        // ---------------- start clears illegal; wrap from 0xFE ----------------
        base_a = 8'hFE; start_a = 1'b1;
        tick;
        start_a = 1'b0;
        check("start clr illegal", 32'(illegal_a), 32'h0);
        check("start clr count",   32'(count_a),   32'h0);
        bus_a.in_valid = 1'b1;
        tick;
        check("wrap addr0", 32'(bus_a.imem_addr), 32'h0FE);
        tick;
        check("wrap addr1", 32'(bus_a.imem_addr), 32'h0FF);
        tick;
        bus_a.in_valid = 1'b0;
        check("wrap addr2",  32'(bus_a.imem_addr), 32'h000);
        check("wrap we2",    32'(bus_a.imem_we),   32'h1);
        check("wrap count",  32'(count_a),         32'h3);
        tick;
        check("wrap idle we", 32'(bus_a.imem_we), 32'h0);

        // ---------------- start during PAD drops the NOP ----------------
        drive_a(jal_v);
        bus_a.in_valid = 1'b1;
        tick;
        bus_a.in_valid = 1'b0;
        check("jal2 wdata", bus_a.imem_wdata, 32'h0C000123);
        base_a = 8'h40; start_a = 1'b1;
        #1;
        check("pad+start ready", 32'(bus_a.in_ready), 32'h0);
        tick;
        start_a = 1'b0;
        check("pad+start no we", 32'(bus_a.imem_we), 32'h0);
        check("pad+start count", 32'(count_a),       32'h0);
        tick;
        check("pad+start still no we", 32'(bus_a.imem_we),  32'h0);
        check("pad+start ready idle",  32'(bus_a.in_ready), 32'h1);

        // ---------------- reset during PAD ----------------
        drive_a(vecs[3]);
        bus_a.in_valid = 1'b1;
        tick;
        bus_a.in_valid = 1'b0;
        check("jal@40 addr",  32'(bus_a.imem_addr), 32'h040);
        check("jal@40 wdata", bus_a.imem_wdata,     32'h0C000040);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("pad+rst we",    32'(bus_a.imem_we),   32'h0);
        check("pad+rst count", 32'(count_a),         32'h0);
        check("pad+rst addr",  32'(bus_a.imem_addr), 32'h0);
        tick;
        check("pad+rst no nop", 32'(bus_a.imem_we), 32'h0);
        check("pad+rst count2", 32'(count_a),       32'h0);

        // ---------------- DEPTH=4: pad dropped on the last slot ----------------
        base_b = 8'h00; start_b = 1'b1;
        tick;
        start_b = 1'b0;
        drive_b(add_v);
        bus_b.in_valid = 1'b1;
        tick; tick; tick;
        check("b count3", 32'(count_b), 32'h3);
        check("b full3",  32'(full_b),  32'h0);
        drive_b(bleu_v);
        tick;
        check("b bleu we",    32'(bus_b.imem_we),   32'h1);
        check("b bleu addr",  32'(bus_b.imem_addr), 32'h3);
        check("b bleu wdata", bus_b.imem_wdata,     32'h40000008);
        check("b count4",     32'(count_b),         32'h4);
        check("b full",       32'(full_b),          32'h1);
        check("b overflow",   32'(overflow_b),      32'h1);
        check("b ready full", 32'(bus_b.in_ready),  32'h0);
        tick;
        bus_b.in_valid = 1'b0;
        check("b no pad we",   32'(bus_b.imem_we), 32'h0);
        check("b count held",  32'(count_b),       32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ins_encoder_loader.md
Name: ins_encoder_loader

Overview:
- Encoder for the team's 32-bit ISA: takes decoded instruction requests (mnemonic plus fields) over a valid/ready handshake and packs each one into the instruction word that Control decodes.
- Writes packed words sequentially into the instruction-memory write port.
- Used by the program loader and the test harness to fill instruction memory.
- Optionally pads each control-transfer instruction with a NOP delay slot.

Parameters:
- AW, 8, instruction-memory address width (word addressed).
- DEPTH, 256, maximum number of words written per program (1..2^AW).
- PAD_DELAY_SLOT, 1, when 1, emit NOP word 32'h0 after every BLEU/JR/JAL.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse: load base_addr, clear count and sticky flags.
- base_addr  in  AW  first write address, sampled when start=1.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_op  in  4  mnemonic, op_e.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_imm  in  16  immediate field.
- in_target  in  26  jump target field.
- imem_we  out  1  write strobe.
- imem_addr  out  AW  write address.
- imem_wdata  out  32  encoded word.
- count  out  AW+1  words written since start.
- full  out  1  count == DEPTH.
- illegal  out  1  sticky: an undefined in_op was consumed.
- overflow  out  1  sticky: a delay-slot pad was dropped for lack of space.

Behaviour:
- Opcode occupies ins[31:26]:
  - LW=100011, SW=101011, ADD=100000, JR=001000, JAL=000011
  - NOR=100110, NORI=001110, NOT=000100, BLEU=010000, ROLV=000000, RORV=000010
- Field packing:
  - ADD/NOR/ROLV/RORV: {opc, rs, rt, rd, 11'b0}
  - LW/SW/NORI/BLEU: {opc, rs, rt, imm}
  - NOT: {opc, rs, rt, 16'b0}
  - JR: {opc, rs, 21'b0}
  - JAL: {opc, target}
- op_e encoding: LW=0, SW=1, ADD=2, JR=3, JAL=4, NOR=5, NORI=6, NOT=7, BLEU=8, ROLV=9, RORV=10. Values 11..15 are illegal.
- Reset state: state=IDLE, in_ready=0 during the reset cycle, imem_we=0, imem_addr=0, imem_wdata=0, count=0, full=0, illegal=0, overflow=0. The write pointer is 0 until start.
- States:
  - IDLE: in_ready = ~full.
  - PAD: in_ready = 0; NOP pending.
- Latency: a request accepted in cycle t produces imem_we=1 in cycle t+1, with imem_addr = base+count and wdata = packed word. count increments in the same cycle as the write. imem_we=0 in every cycle without a write.
- BLEU/JR/JAL with PAD_DELAY_SLOT=1:
  - The transition to PAD happens in cycle t+1.
  - In cycle t+2, NOP 32'h0 is written at the next address, count increments, and the state returns to IDLE.
  - If the instruction itself filled the last slot, the pad is dropped, overflow=1, and the state returns directly to IDLE.
- Illegal in_op: the request is consumed with no write, count is unchanged, and illegal=1.
- Address arithmetic is modulo 2^AW, so base_addr + count wraps. full depends on count only.
- Simultaneous events:
  - start has priority over acceptance. in_ready=0 in the start cycle.
  - start clears a pending PAD without writing it.
  - A write already registered from cycle t-1 still completes.
- Reset mid-operation: a pending PAD and the registered write are discarded, and all outputs return to reset values next cycle.

Decomposition:
- Package isa_pkg holds:
  - typedef op_e
  - 6-bit opcode localparams
  - field LSB/width constants (OPC_LSB=26, RS_LSB=21, RT_LSB=16, RD_LSB=11)
  - NOP_WORD=32'h0
- Sub-module ins_field_pack: a purely combinational op/fields-to-word packer that also reports illegal and is_ctrl. It is shared with future assembler/verification models.

Test Plan:
- start base_addr=0x10; ADD rs=1 rt=2 rd=3 -> next cycle imem_we=1, addr=0x10, wdata=0x80221800, count=1.
- LW rs=4 rt=5 imm=0xFFFC -> wdata=0x8C85FFFC at the next address; then NOT rs=1 rt=2 -> wdata=0x10220000.
- JAL target=0x40 at addr N -> 0x0C000040 at N, then 0x00000000 at N+1; in_ready=0 for one cycle; count +2.
- in_op=4'hF -> no imem_we, illegal=1, count unchanged; the following ADD writes at the unchanged address. A later start clears illegal.
- DEPTH=4: three ADDs then BLEU imm=0x0008 -> 0x40000008 written, pad dropped, overflow=1, full=1, in_ready=0.
- base_addr=0xFE with two ADDs -> writes at 0xFE, 0xFF, then a third at 0x00. reset asserted during PAD -> no NOP written, count=0, imem_we=0.
